// File: rtl/sram_word_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit async SRAM accesses padded to a fixed wait count.
// Optional macro SRAM_POSTED_WRITE_EN: stores post into a one-entry buffer and do not stall the pipeline.
module sram_word_ctrl #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);

    localparam int unsigned WORD_W   = ADDR_W - 1;
    localparam int unsigned CNT_W    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned CNT_LASTV = (WAIT_CYCLES > 2) ? (WAIT_CYCLES - 3) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LASTV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC_LO,
        S_ACC_HI,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_write;
    logic [WORD_W-1:0]  r_word;
    logic [15:0]        r_wdata_hi;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_read_data;
    logic [ADDR_W-1:0]  r_sram_addr;
    logic [15:0]        r_sram_dq_out;
    logic               r_sram_dq_oe;
    logic               r_sram_we_n;

    logic               w_req;
    logic [WORD_W-1:0]  w_word;
    state_t             w_end_state;
    logic               w_unused;

    assign w_req    = rd_en | wr_en;
    assign w_word   = address[ADDR_W:2];
    assign w_unused = ^{address[31:ADDR_W+1], address[1:0]};

    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;
    assign sram_we_n   = r_sram_we_n;

`ifdef SRAM_POSTED_WRITE_EN
    // Posted writes skip DONE; only reads hand a result back to the pipeline.
    assign w_end_state = r_write ? S_IDLE : S_DONE;

    always_comb begin
        ready = 1'b0;
        case (r_state)
            S_IDLE:  ready = !rd_en || wr_en;
            S_DONE:  ready = 1'b1;
            default: ready = r_write && !w_req;
        endcase
    end
`else
    assign w_end_state = S_DONE;

    always_comb begin
        ready = (r_state == S_DONE) || ((r_state == S_IDLE) && !w_req);
    end
`endif

    // Access sequencer; SRAM strobes are registered so address/data are stable for whole cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_word        <= '0;
            r_wdata_hi    <= '0;
            r_cnt         <= '0;
            r_read_data   <= '0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= '0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state       <= S_ACC_LO;
                        r_write       <= wr_en;
                        r_word        <= w_word;
                        r_wdata_hi    <= write_data[31:16];
                        r_sram_addr   <= {w_word, 1'b0};
                        r_sram_dq_out <= write_data[15:0];
                        r_sram_dq_oe  <= wr_en;
                        r_sram_we_n   <= !wr_en;
                    end
                end
                S_ACC_LO: begin
                    if (!r_write) begin
                        r_read_data[15:0] <= sram_dq_in;
                    end
                    r_state       <= S_ACC_HI;
                    r_sram_addr   <= {r_word, 1'b1};
                    r_sram_dq_out <= r_wdata_hi;
                end
                S_ACC_HI: begin
                    if (!r_write) begin
                        r_read_data[31:16] <= sram_dq_in;
                    end
                    r_sram_we_n  <= 1'b1;
                    r_sram_dq_oe <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= (WAIT_CYCLES > 2) ? S_WAIT : w_end_state;
                end
                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= w_end_state;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_word_ctrl.md
# sram_word_ctrl

Multi-cycle controller that sits between the MEM stage and an external 16-bit asynchronous SRAM. It takes single-cycle 32-bit load/store requests from the pipeline and splits each into two half-word SRAM accesses. It pads every access to a fixed wait-state count and holds `ready` low so the hazard/freeze logic stalls IF/ID/EXE/MEM until the access completes.

## Interface

Parameters:
- `ADDR_W`, default 18: SRAM half-word address width.
- `WAIT_CYCLES`, default 5: busy cycles per access after the request cycle; must be ≥2.

Ports:
- `clk` input, 1: single clock; all state changes on its rising edge.
- `rst` input, 1: synchronous, active-low reset.
- `rd_en` input, 1: load request from MEM stage.
- `wr_en` input, 1: store request from MEM stage.
- `address` input, 32: byte address (ALU result); bits [1:0] ignored.
- `write_data` input, 32: store data (Val_Rm).
- `read_data` output, 32: load result; valid when `ready`=1 after a read.
- `ready` output, 1: 0 = freeze pipeline; combinational from state and requests.
- `sram_addr` output, ADDR_W: SRAM half-word address.
- `sram_dq_out` output, 16: data driven to SRAM.
- `sram_dq_oe` output, 1: 1 = controller drives DQ bus.
- `sram_dq_in` input, 16: data from SRAM; the SRAM read path is combinational.
- `sram_we_n` output, 1: active-low SRAM write strobe.

## Operation

- State machine states: IDLE, ACC_LO, ACC_HI, WAIT, DONE.
- The block latches `address`, `write_data` and the operation type on leaving IDLE. Later input changes do not affect the access in flight.
- Half-word addressing: low half is `{address[ADDR_W:2], 1'b0}`, high half is `{address[ADDR_W:2], 1'b1}`. Higher address bits are ignored, so addresses wrap modulo 2^(ADDR_W+1) bytes.
- IDLE → ACC_LO when `rd_en|wr_en`. If both are asserted, the access is a write.
- ACC_LO:
  - Drives the low address.
  - Write: `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_out`=`write_data[15:0]`.
  - Read: `sram_we_n`=1, `sram_dq_oe`=0, and `read_data[15:0]` ← `sram_dq_in` at the clock edge.
- ACC_HI: same as ACC_LO using the high address, `write_data[31:16]` and `read_data[31:16]`.
- WAIT:
  - Counter counts `WAIT_CYCLES`-2 cycles.
  - `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr` holds.
  - With `WAIT_CYCLES`=2 the state is skipped and ACC_HI → DONE.
- DONE: one cycle, then → IDLE unconditionally.
- `ready`:
  - 0 in IDLE with a request pending, and in ACC_LO, ACC_HI and WAIT.
  - 1 in DONE, and in IDLE with no request.
- Dropping `rd_en`/`wr_en` mid-access does not abort it; the access runs to DONE.
- `read_data` holds its last value until the next read overwrites it. Writes do not change it.
- Reset mid-access:
  - Next edge goes to IDLE and aborts the access; a partially written word is permitted.
  - Reset values: `read_data`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_dq_out`=0, `sram_addr`=0, counter=0.

## Timing

- Request present at IDLE cycle T: `ready`=0 combinationally in T. ACC_LO is T+1, ACC_HI is T+2, WAIT is T+3…T+WAIT_CYCLES, DONE is T+WAIT_CYCLES+1.
- Stall length: `ready` is low for exactly WAIT_CYCLES+1 cycles (6 at default), then high for one cycle.
- Back-to-back requests: the IDLE cycle after DONE samples the next request. Minimum request spacing is WAIT_CYCLES+2 cycles.
- `sram_we_n` is low for exactly 2 cycles per write, with address and data stable for the whole of each cycle.

## Configuration

- Macro: `SRAM_POSTED_WRITE_EN`.
- Defined:
  - A write in IDLE is latched into a one-entry buffer and `ready` stays 1 (no stall).
  - The buffer drains through ACC_LO/ACC_HI/WAIT and then returns directly to IDLE; DONE is used only for reads.
  - Any request arriving while the buffer is draining sees `ready`=0 until the drain completes. It is then processed normally from IDLE.
- Undefined: writes stall exactly like reads, as described above.

## Test plan

- Reset: hold `rst`=0 for 2 cycles, then release. Expect `ready`=1, `read_data`=0, `sram_we_n`=1, `sram_dq_oe`=0.
- Write: `wr_en`=1, `address`=0x0000_0404, `write_data`=0xDEAD_BEEF at T.
  - `sram_addr`=0x202 with `sram_dq_out`=0xBEEF at T+1.
  - `sram_addr`=0x203 with 0xDEAD at T+2.
  - `ready`=0 during T…T+5 and 1 at T+6.
- Read back: `rd_en`=1 at 0x0000_0404 with the SRAM model preloaded. Expect `read_data`=0xDEAD_BEEF with `ready`=1 exactly 6 cycles after the request.
- Conflicts and drops:
  - `rd_en`=`wr_en`=1 performs a write.
  - Deasserting `rd_en` at T+2 still completes the access, with `ready`=1 at T+6.
- Reset mid-access: assert `rst`=0 at T+2 of a write. Expect IDLE next cycle, `sram_we_n`=1, `ready`=1 with no request pending.
- Posted writes (`SRAM_POSTED_WRITE_EN` defined): issue a write then a read on consecutive cycles.
  - Write sees `ready`=1.
  - Read sees `ready`=0 until the drain completes.
  - Read returns the just-written word.
